// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    // Wide enough for MEM_LAT-1 with MEM_LAT up to 15.
    localparam int LAT_W = 4;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of the CPU port, debug port and memory-side signals around mem_arb.
interface mem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_stall;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_ack;

    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          owner;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack,
        output mem_re, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output owner
    );

    // Requesters plus memory: everything the arbiter drives is seen here as input.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack,
        input  mem_re, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  owner
    );

endinterface

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin picker; the last_owner state is held by the caller.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_id_o    = OWN_CPU;
        if (req_i == 2'b11) begin
            gnt_id_o = ~last_owner_i;
        end else if (req_i[1]) begin
            gnt_id_o = OWN_DBG;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Serializes CPU and debug accesses to the unified memory: arbitrate in IDLE,
// drive memory for MEM_LAT cycles in ACCESS, pulse the owner's ack in RESP.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic     clk,
    input  logic     reset,
    mem_arb_if.slave bus
);

    localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'(MEM_LAT - 1);

    state_e           state_q, state_d;
    logic             last_owner_q, last_owner_d;
    logic             owner_q, owner_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]    dbg_rdata_q, dbg_rdata_d;

    logic             gnt_valid;
    logic             gnt_id;

    mem_arb_rr u_rr (
        .req_i        ({bus.dbg_req, bus.cpu_req}),
        .last_owner_i (last_owner_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_id_o     (gnt_id)
    );

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d = gnt_id;
                    we_d    = (gnt_id == OWN_DBG) ? bus.dbg_we    : bus.cpu_we;
                    addr_d  = (gnt_id == OWN_DBG) ? bus.dbg_addr  : bus.cpu_addr;
                    wdata_d = (gnt_id == OWN_DBG) ? bus.dbg_wdata : bus.cpu_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    // Memory data is only guaranteed on the last ACCESS cycle.
                    if (!we_q) begin
                        if (owner_q == OWN_DBG) dbg_rdata_d = bus.mem_rdata;
                        else                    cpu_rdata_d = bus.mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    // NOTE: the rdata holding registers are plain flops with defined reset values, not a RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_owner_q <= OWN_DBG;
            owner_q      <= OWN_CPU;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    // The write strobe is limited to the first ACCESS cycle: one write per transaction.
    assign bus.mem_re    = (state_q == ACCESS) && !we_q;
    assign bus.mem_we    = (state_q == ACCESS) && we_q && (cnt_q == CNT_INIT);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.cpu_ack   = (state_q == RESP) && (owner_q == OWN_CPU);
    assign bus.dbg_ack   = (state_q == RESP) && (owner_q == OWN_DBG);
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.cpu_stall = bus.cpu_req && !bus.cpu_ack;
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed scoreboard bench for mem_arb: MEM_LAT=2 main instance plus MEM_LAT=1/15 builds.
module tb_mem_arb;
    import mem_arb_pkg::*;

    logic clk;
    logic reset;

    mem_arb_if #(.AW(32), .DW(32)) bus  ();
    mem_arb_if #(.AW(32), .DW(32)) bus1 ();
    mem_arb_if #(.AW(32), .DW(32)) bus15();

    mem_arb #(.AW(32), .DW(32), .MEM_LAT(2))  u_dut (.clk(clk), .reset(reset), .bus(bus));
    mem_arb #(.AW(32), .DW(32), .MEM_LAT(1))  u_l1  (.clk(clk), .reset(reset), .bus(bus1));
    mem_arb #(.AW(32), .DW(32), .MEM_LAT(15)) u_l15 (.clk(clk), .reset(reset), .bus(bus15));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] cpu_m, dbg_m;
    int          cyc;
    int          n_checks, n_fail;
    int          re_cnt, we_cnt;
    logic [31:0] we_addr, we_data;
    logic        last_cpu_ack;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit has_port(input logic p);
        foreach (sb[i]) if (sb[i].port == p) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input logic port, input logic we, input logic [31:0] rdata, input int at);
        exp_t e;
        e.port = port; e.we = we; e.rdata = rdata; e.cyc = at;
        sb.push_back(e);
    endtask

    // Pops the scoreboard on every ack and releases a port's req once it has nothing queued.
    task automatic monitor();
        exp_t e;
        if (bus.cpu_ack || bus.dbg_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {62'd0, bus.cpu_ack, bus.dbg_ack}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("ack_both", {63'd0, bus.cpu_ack & bus.dbg_ack}, 64'd0);
                check("ack_port", {63'd0, bus.dbg_ack}, {63'd0, e.port});
                check("ack_owner", {63'd0, bus.owner}, {63'd0, e.port});
                check("ack_cycle", 64'(cyc), 64'(e.cyc));
                if (!e.we && e.port == OWN_CPU) cpu_m = e.rdata;
                if (!e.we && e.port == OWN_DBG) dbg_m = e.rdata;
                check("cpu_rdata", {32'd0, bus.cpu_rdata}, {32'd0, cpu_m});
                check("dbg_rdata", {32'd0, bus.dbg_rdata}, {32'd0, dbg_m});
                if (e.port == OWN_CPU) check("stall_at_ack", {63'd0, bus.cpu_stall}, 64'd0);
                if (e.port == OWN_CPU && !has_port(OWN_CPU)) bus.cpu_req = 1'b0;
                if (e.port == OWN_DBG && !has_port(OWN_DBG)) bus.dbg_req = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        last_cpu_ack = bus.cpu_ack;
        if (bus.mem_re) re_cnt++;
        if (bus.mem_we) begin
            we_cnt++;
            we_addr = bus.mem_addr;
            we_data = bus.mem_wdata;
            mem[bus.mem_addr] = bus.mem_wdata;
        end
        monitor();
        bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'd0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) step();
        check("timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_vals();
        check("rst_cpu_ack",   {63'd0, bus.cpu_ack},   64'd0);
        check("rst_dbg_ack",   {63'd0, bus.dbg_ack},   64'd0);
        check("rst_mem_re",    {63'd0, bus.mem_re},    64'd0);
        check("rst_mem_we",    {63'd0, bus.mem_we},    64'd0);
        check("rst_mem_addr",  {32'd0, bus.mem_addr},  64'd0);
        check("rst_mem_wdata", {32'd0, bus.mem_wdata}, 64'd0);
        check("rst_cpu_rdata", {32'd0, bus.cpu_rdata}, 64'd0);
        check("rst_dbg_rdata", {32'd0, bus.dbg_rdata}, 64'd0);
        check("rst_owner",     {63'd0, bus.owner},     64'd0);
        check("rst_cpu_stall", {63'd0, bus.cpu_stall}, 64'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        sb.delete();
        cpu_m = '0;
        dbg_m = '0;
        #1;
        check_reset_vals();
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int t, ack1, ack15, we1, we15;
        n_checks = 0; n_fail = 0; cyc = 0; re_cnt = 0; we_cnt = 0;
        we_addr = '0; we_data = '0; last_cpu_ack = 1'b0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        bus.mem_rdata = '0;
        bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
        bus1.dbg_req = 0; bus1.dbg_we = 0; bus1.dbg_addr = '0; bus1.dbg_wdata = '0;
        bus1.mem_rdata = '0;
        bus15.cpu_req = 0; bus15.cpu_we = 0; bus15.cpu_addr = '0; bus15.cpu_wdata = '0;
        bus15.dbg_req = 0; bus15.dbg_we = 0; bus15.dbg_addr = '0; bus15.dbg_wdata = '0;
        bus15.mem_rdata = '0;
        mem[32'h10] = 32'h2008_0005;

        apply_reset();

        // CPU read of 0x10.
        step();
        t = cyc; re_cnt = 0; we_cnt = 0;
        bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10; bus.cpu_req = 1'b1;
        push(OWN_CPU, 1'b0, 32'h2008_0005, t + 3);
        wait_done(20);
        check("rd_re_cycles", 64'(re_cnt), 64'd2);
        check("rd_we_cycles", 64'(we_cnt), 64'd0);

        // Debug write of 0xDEADBEEF to 0x40.
        step();
        t = cyc; re_cnt = 0; we_cnt = 0;
        bus.dbg_we = 1'b1; bus.dbg_addr = 32'h40; bus.dbg_wdata = 32'hDEAD_BEEF; bus.dbg_req = 1'b1;
        push(OWN_DBG, 1'b1, 32'd0, t + 3);
        wait_done(20);
        check("wr_we_cycles", 64'(we_cnt), 64'd1);
        check("wr_re_cycles", 64'(re_cnt), 64'd0);
        check("wr_addr", {32'd0, we_addr}, 64'h40);
        check("wr_data", {32'd0, we_data}, 64'hDEAD_BEEF);

        // Both request right after reset and stay high: CPU, DBG, CPU, DBG.
        apply_reset();
        t = cyc;
        bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10; bus.cpu_req = 1'b1;
        bus.dbg_we = 1'b0; bus.dbg_addr = 32'h40; bus.dbg_req = 1'b1;
        push(OWN_CPU, 1'b0, 32'h2008_0005, t + 3);
        push(OWN_DBG, 1'b0, 32'hDEAD_BEEF, t + 7);
        push(OWN_CPU, 1'b0, 32'h2008_0005, t + 11);
        push(OWN_DBG, 1'b0, 32'hDEAD_BEEF, t + 15);
        wait_done(40);

        // CPU request arriving while a debug write is in ACCESS stalls until its ack.
        step();
        t = cyc;
        bus.dbg_we = 1'b1; bus.dbg_addr = 32'h44; bus.dbg_wdata = 32'h1234_5678; bus.dbg_req = 1'b1;
        push(OWN_DBG, 1'b1, 32'd0, t + 3);
        step();
        bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40; bus.cpu_req = 1'b1;
        push(OWN_CPU, 1'b0, 32'hDEAD_BEEF, t + 7);
        #1;
        check("stall_wait", {63'd0, bus.cpu_stall}, 64'd1);
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            step();
            if (!last_cpu_ack) check("stall_wait", {63'd0, bus.cpu_stall}, 64'd1);
        end
        check("timeout", 64'(sb.size()), 64'd0);

        // Reset in the second ACCESS cycle of a CPU read: no ack, reset values, then recovery.
        step();
        bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10; bus.cpu_req = 1'b1;
        step();
        step();
        bus.cpu_req = 1'b0;
        reset = 1'b1;
        cpu_m = '0;
        dbg_m = '0;
        #1;
        check_reset_vals();
        step();
        step();
        reset = 1'b0;
        step();
        step();
        t = cyc;
        bus.dbg_we = 1'b0; bus.dbg_addr = 32'h44; bus.dbg_req = 1'b1;
        push(OWN_DBG, 1'b0, 32'h1234_5678, t + 3);
        wait_done(20);
        check("post_rst_owner", {63'd0, bus.owner}, {63'd0, OWN_DBG});

        // MEM_LAT=1 and MEM_LAT=15 builds: ack latency and single write strobe.
        step();
        t = cyc; ack1 = -1; ack15 = -1; we1 = 0; we15 = 0;
        bus1.cpu_we = 1'b1;  bus1.cpu_addr = 32'h8;   bus1.cpu_wdata = 32'hA5A5_A5A5;  bus1.cpu_req = 1'b1;
        bus15.cpu_we = 1'b1; bus15.cpu_addr = 32'hC;  bus15.cpu_wdata = 32'h5A5A_5A5A; bus15.cpu_req = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            if (bus1.mem_we) we1++;
            if (bus15.mem_we) begin
                we15++;
                check("l15_wr_addr", {32'd0, bus15.mem_addr}, 64'hC);
            end
            if (bus1.cpu_ack && ack1 < 0) begin ack1 = cyc; bus1.cpu_req = 1'b0; end
            if (bus15.cpu_ack && ack15 < 0) begin ack15 = cyc; bus15.cpu_req = 1'b0; end
        end
        check("l1_ack_cycle", 64'(ack1), 64'(t + 2));
        check("l15_ack_cycle", 64'(ack15), 64'(t + 16));
        check("l1_we_strobes", 64'(we1), 64'd1);
        check("l15_we_strobes", 64'(we15), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
